sd_spi_host_cmd: RTL and testbench
==================================

// Module: sd_spi_host_cmd
// PURPOSE
//  Host-side SPI-mode SD command initiator. Drives the card's CS/CLK/DI pins and samples DO.
//  Issues the power-up dummy-clock sequence, serialises 48-bit command frames with CRC7,
//  and captures the R1 response byte. It sits between the photo-frame controller FSM and the card pins.
// PARAMETERS
//  CLK_DIV      4    CLK cycles per SCLK half-period (>=1); SCLK = CLK/(2*CLK_DIV)
//  INIT_CLOCKS  80   SCLK pulses sent with CS high on init_req (>=74)
//  RESP_TIMEOUT 8    max bytes (8 SCLK each) to wait for the R1 start bit
// PORTS
//  CLK       in   1   system clock, all logic on posedge
//  RST       in   1   asynchronous, active-high reset
//  init_req  in   1   1-cycle pulse: run dummy-clock sequence
//  cmd_req   in   1   1-cycle pulse: send command cmd_idx/cmd_arg
//  cmd_idx   in   6   command index, sampled on accepted cmd_req
//  cmd_arg   in   32  command argument, sampled on accepted cmd_req
//  busy      out  1   high from accepted request until done
//  done      out  1   1-cycle pulse at end of init or command
//  resp      out  8   R1 byte, valid from done until next accepted request
//  timeout   out  1   with done: no R1 start bit within RESP_TIMEOUT bytes
//  sd_cs     out  1   card chip select, active low
//  sd_clk    out  1   SPI clock, mode 0, idle low
//  sd_di     out  1   MOSI to card DI, idle high
//  sd_do     in   1   MISO from card DO
// BEHAVIOUR
//  Reset: sd_cs=1, sd_clk=0, sd_di=1, busy=0, done=0, resp=8'hFF, timeout=0, FSM=IDLE.
//  Reset mid-operation aborts immediately to these values. No partial frame resumes.
//  SCLK: divider counter runs only outside IDLE. sd_clk toggles on each CLK_DIV-count terminal.
//   sd_di changes only with the falling SCLK edge. sd_do is sampled on the rising SCLK edge.
//  Requests are accepted only in IDLE, else ignored. Simultaneous init_req and cmd_req: init wins.
//  FSM:
//   IDLE     -> INIT on init_req; -> SEND on cmd_req (latch frame, busy=1)
//   INIT     sd_cs=1, sd_di=1, INIT_CLOCKS rising edges -> DONE
//   SEND     sd_cs=0, shift 48 bits MSB first; frame={2'b01,idx,arg,crc7,1'b1} -> WAIT
//   WAIT     sd_di=1. First sampled sd_do=0 is R1 bit7 -> RECV.
//            After RESP_TIMEOUT*8 rising edges with no 0: resp=8'hFF, timeout=1 -> TRAIL
//   RECV     shift 7 more bits MSB first into resp -> TRAIL
//   TRAIL    sd_cs=1, sd_di=1, 8 SCLK pulses (Nec) -> DONE
//   DONE     done=1 for one CLK, busy=0, sd_clk low -> IDLE
//  Every state leaves on a falling-edge boundary, so sd_clk is always low in IDLE.
//  CRC7: poly x^7+x^3+1, init 0, over the first 40 frame bits, computed serially during SEND.
//   The CRC bits are muxed onto sd_di after bit 40.
//  Counters: bit count 6b (0..47), init count sized for INIT_CLOCKS, timeout count
//   sized for RESP_TIMEOUT*8. None may wrap; each state exits on terminal count.
//  A response 0 bit in the same SCLK as the last frame bit is not sampled (Ncr>=1).
// STRUCTURE
//  sd_spi_defs.vh: state encodings, CMD0=0, CMD8=8, CMD17=17, CMD55=55, ACMD41=41,
//   R1 bit masks (IDLE=0x01, ILLEGAL=0x04), START_BITS=2'b01, STOP_BIT=1'b1.
//  Sub-module sd_crc7: serial CRC7 with clr, en and bit inputs and a 7-bit crc output. The FSM drives it.
//  Top holds the FSM, SCLK divider, 48-bit TX shifter, 8-bit RX shifter and counters.
// TESTING (bench: behavioural SPI SD responder, CLK_DIV=2)
//  1 init_req -> exactly 80 sd_clk rising edges with sd_cs=1 and sd_di=1; done after them; resp untouched.
//  2 cmd_req CMD0 arg 0 -> sd_di stream 40 00 00 00 00 95.
//    Responder replies 0x01 after 2 bytes -> resp=8'h01, timeout=0, then 8 trailing clocks.
//  3 cmd_req CMD8 arg 32'h1AA -> frame 48 00 00 01 AA 87; responder 0x05 -> resp=8'h05.
//  4 Responder silent (sd_do=1) -> done after 64 WAIT edges + 8 trail; resp=8'hFF, timeout=1.
//  5 cmd_req while busy, and init_req+cmd_req in the same cycle ->
//    first ignored (frame unchanged), second runs INIT only.
//  6 RST asserted mid-SEND (bit 20) -> same-cycle sd_cs=1, sd_clk=0, busy=0.
//    Next CMD0 is bit-exact as in test 2.

Source files
------------

// File: rtl/sd_spi_host_cmd_pkg.sv
// Shared definitions for the SPI-mode SD command initiator: FSM states,
// command indices, R1 masks, frame constants and the serial CRC7 step.
package sd_spi_host_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_TRAIL,
    ST_DONE
  } state_t;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;

  localparam logic [1:0] START_BITS = 2'b01;
  localparam logic       STOP_BIT   = 1'b1;

  localparam logic [6:0] CRC7_POLY  = 7'h09;

  // One serial step of x^7 + x^3 + 1, message bits entering MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_host_cmd_crc7.sv
// Serial CRC7 accumulator for SD command frames; cleared per frame and fed
// one bit per rising SCLK while the first 40 frame bits are on the wire.
module sd_crc7
  import sd_spi_host_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_spi_host_cmd.sv
// Host-side SPI-mode SD command initiator: power-up dummy clocks, 48-bit
// command frames with CRC7, and R1 response capture with timeout.
module sd_spi_host_cmd
  import sd_spi_host_cmd_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int INIT_CLOCKS  = 80,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        init_req,
  input  logic        cmd_req,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        sd_cs,
  output logic        sd_clk,
  output logic        sd_di,
  input  logic        sd_do
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int INIT_W = $clog2(INIT_CLOCKS + 1);
  localparam int TO_W   = $clog2(RESP_TIMEOUT * 8 + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CLOCKS);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RESP_TIMEOUT * 8);

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [INIT_W-1:0] init_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              got_start;

  logic [47:0]       tx_sr;
  logic [7:0]        rx_sr;
  logic [6:0]        crc;

  logic active;
  logic tick;
  logic sclk_rise;
  logic sclk_fall;
  logic accept_cmd;
  logic crc_en;

  always_comb begin
    active     = (state != ST_IDLE) && (state != ST_DONE);
    tick       = active && (div_cnt == DIV_LAST);
    sclk_rise  = tick && !sd_clk;
    sclk_fall  = tick && sd_clk;
    accept_cmd = (state == ST_IDLE) && cmd_req && !init_req;
    crc_en     = (state == ST_SEND) && sclk_rise && (bit_cnt < 6'd40);
  end

  sd_crc7 u_crc7 (
    .clk    (CLK),
    .clr    (accept_cmd),
    .en     (crc_en),
    .bit_in (tx_sr[47]),
    .crc    (crc)
  );

  // Datapath shifters: tx_sr[47] always mirrors the bit currently on sd_di.
  always_ff @(posedge CLK) begin
    if (accept_cmd) begin
      tx_sr <= {START_BITS, cmd_idx, cmd_arg, 7'h00, STOP_BIT};
    end else if ((state == ST_SEND) && sclk_fall) begin
      if (bit_cnt == 6'd39) begin
        tx_sr <= {crc, STOP_BIT, 40'h0};
      end else begin
        tx_sr <= {tx_sr[46:0], 1'b1};
      end
    end

    if ((state == ST_WAIT) && sclk_rise) begin
      rx_sr <= 8'h00;
    end else if ((state == ST_RECV) && sclk_rise) begin
      rx_sr <= {rx_sr[6:0], sd_do};
    end
  end

  // Control FSM, SCLK divider and pin drivers; transitions land on falling SCLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      init_cnt  <= '0;
      to_cnt    <= '0;
      got_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp      <= 8'hFF;
      timeout   <= 1'b0;
      sd_cs     <= 1'b1;
      sd_clk    <= 1'b0;
      sd_di     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (active) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) begin
          sd_clk <= ~sd_clk;
        end
      end

      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          if (init_req) begin
            state    <= ST_INIT;
            busy     <= 1'b1;
            timeout  <= 1'b0;
            init_cnt <= '0;
            sd_cs    <= 1'b1;
            sd_di    <= 1'b1;
          end else if (cmd_req) begin
            state   <= ST_SEND;
            busy    <= 1'b1;
            timeout <= 1'b0;
            bit_cnt <= '0;
            sd_cs   <= 1'b0;
            sd_di   <= START_BITS[1];
          end
        end

        ST_INIT: begin
          if (sclk_rise) begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
          if (sclk_fall && (init_cnt == INIT_LAST)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        ST_SEND: begin
          if (sclk_fall) begin
            if (bit_cnt == 6'd47) begin
              state     <= ST_WAIT;
              sd_di     <= 1'b1;
              to_cnt    <= '0;
              got_start <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              sd_di   <= (bit_cnt == 6'd39) ? crc[6] : tx_sr[46];
            end
          end
        end

        ST_WAIT: begin
          if (sclk_rise) begin
            to_cnt    <= to_cnt + TO_W'(1);
            got_start <= ~sd_do;
          end
          if (sclk_fall) begin
            if (got_start) begin
              state   <= ST_RECV;
              bit_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              state   <= ST_TRAIL;
              resp    <= 8'hFF;
              timeout <= 1'b1;
              sd_cs   <= 1'b1;
              bit_cnt <= '0;
            end
          end
        end

        ST_RECV: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 6'd1;
          end
          if (sclk_fall && (bit_cnt == 6'd7)) begin
            state   <= ST_TRAIL;
            resp    <= rx_sr;
            sd_cs   <= 1'b1;
            bit_cnt <= '0;
          end
        end

        ST_TRAIL: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 6'd1;
          end
          if (sclk_fall && (bit_cnt == 6'd8)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_host_cmd.sv
// Directed bench for sd_spi_host_cmd with a behavioural SPI-mode SD responder.
module tb_sd_spi_host_cmd;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_req = 1'b0;
  logic        cmd_req = 1'b0;
  logic [5:0]  cmd_idx = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        busy, done, timeout, sd_cs, sd_clk, sd_di;
  logic [7:0]  resp;
  logic        sd_do = 1'b1;

  sd_spi_host_cmd #(.CLK_DIV(2), .INIT_CLOCKS(80), .RESP_TIMEOUT(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .init_req (init_req),
    .cmd_req  (cmd_req),
    .cmd_idx  (cmd_idx),
    .cmd_arg  (cmd_arg),
    .busy     (busy),
    .done     (done),
    .resp     (resp),
    .timeout  (timeout),
    .sd_cs    (sd_cs),
    .sd_clk   (sd_clk),
    .sd_di    (sd_di),
    .sd_do    (sd_do)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder / pin monitor, sampled on the inactive clock edge.
  logic [63:0] pat = '1;
  logic [47:0] frame = '0;
  int rises_total = 0, rises_hi = 0, rises_lo = 0, di_low_hi = 0;
  int lowcnt = 0;
  logic prev_clk = 1'b0;
  logic m_rise, m_fall;
  int m_idx;

  always @(negedge CLK) begin
    m_rise = sd_clk && !prev_clk;
    m_fall = !sd_clk && prev_clk;
    if (m_rise) begin
      rises_total = rises_total + 1;
      if (sd_cs) begin
        rises_hi = rises_hi + 1;
        if (!sd_di) di_low_hi = di_low_hi + 1;
      end else begin
        rises_lo = rises_lo + 1;
        if (lowcnt < 48) frame = {frame[46:0], sd_di};
        lowcnt = lowcnt + 1;
      end
    end
    if (sd_cs) begin
      lowcnt = 0;
      sd_do  = 1'b1;
    end else if (m_fall && lowcnt >= 48) begin
      m_idx = lowcnt - 48;
      sd_do = (m_idx < 64) ? pat[63 - m_idx] : 1'b1;
    end
    prev_clk = sd_clk;
  end

  int b_total, b_hi, b_lo, b_dilow;
  int d_total, d_hi, d_lo, d_dilow;
  bit ok;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_total = rises_total; b_hi = rises_hi; b_lo = rises_lo; b_dilow = di_low_hi;
  endtask

  task automatic deltas();
    d_total = rises_total - b_total; d_hi = rises_hi - b_hi;
    d_lo = rises_lo - b_lo; d_dilow = di_low_hi - b_dilow;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse(input logic do_init, input logic do_cmd, input logic [5:0] idx,
                       input logic [31:0] arg);
    @(posedge CLK); #1;
    init_req = do_init; cmd_req = do_cmd; cmd_idx = idx; cmd_arg = arg;
    @(posedge CLK); #1;
    init_req = 1'b0; cmd_req = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    wait_done(3000, ok);
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_sclk_low"}, sd_clk, 0);
    check({tag, "_busy_off"}, busy, 0);
    deltas();
    @(posedge CLK); #1;
    check({tag, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cs", sd_cs, 1);
    check("rst_clk", sd_clk, 0);
    check("rst_di", sd_di, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resp", resp, 8'hFF);
    check("rst_timeout", timeout, 0);
    RST = 1'b0;

    // 1: init sequence
    snap();
    pulse(1'b1, 1'b0, 6'd0, 32'd0);
    check("init_busy", busy, 1);
    finish_op("init");
    check("init_rises", d_total, 80);
    check("init_rises_cs_hi", d_hi, 80);
    check("init_di_low", d_dilow, 0);
    check("init_resp", resp, 8'hFF);

    // 2: CMD0, R1=0x01 after two idle bytes
    pat = {16'hFFFF, 8'h01, 40'hFF_FFFF_FFFF};
    snap();
    pulse(1'b0, 1'b1, 6'd0, 32'h0);
    check("cmd0_busy", busy, 1);
    check("cmd0_cs_low", sd_cs, 0);
    finish_op("cmd0");
    check("cmd0_frame", frame, 48'h40_0000_0000_95);
    check("cmd0_resp", resp, 8'h01);
    check("cmd0_timeout", timeout, 0);
    check("cmd0_rises_lo", d_lo, 72);
    check("cmd0_trail", d_hi, 8);

    // 3: CMD8 arg 0x1AA, R1=0x05 after one idle byte
    pat = {8'hFF, 8'h05, 48'hFFFF_FFFF_FFFF};
    snap();
    pulse(1'b0, 1'b1, 6'd8, 32'h0000_01AA);
    finish_op("cmd8");
    check("cmd8_frame", frame, 48'h48_0000_01AA_87);
    check("cmd8_resp", resp, 8'h05);
    check("cmd8_rises_lo", d_lo, 64);
    check("cmd8_trail", d_hi, 8);

    // 4: silent card -> timeout
    pat = '1;
    snap();
    pulse(1'b0, 1'b1, 6'd55, 32'h0);
    finish_op("silent");
    check("silent_frame", frame, 48'h77_0000_0000_65);
    check("silent_resp", resp, 8'hFF);
    check("silent_timeout", timeout, 1);
    check("silent_rises", d_total, 120);
    check("silent_trail", d_hi, 8);

    // 5a: request while busy is ignored
    pat = {8'hFF, 8'h05, 48'hFFFF_FFFF_FFFF};
    snap();
    pulse(1'b0, 1'b1, 6'd8, 32'h0000_01AA);
    repeat (50) @(posedge CLK);
    pulse(1'b0, 1'b1, 6'd0, 32'h0);
    finish_op("busyreq");
    check("busyreq_frame", frame, 48'h48_0000_01AA_87);
    check("busyreq_resp", resp, 8'h05);
    check("busyreq_timeout", timeout, 0);
    snap();
    repeat (100) @(posedge CLK);
    #1;
    deltas();
    check("busyreq_no_replay", d_total, 0);
    check("busyreq_idle", busy, 0);

    // 5b: init and cmd together -> init only
    snap();
    pulse(1'b1, 1'b1, 6'd0, 32'h0);
    check("both_cs_hi", sd_cs, 1);
    finish_op("both");
    check("both_rises", d_total, 80);
    check("both_rises_lo", d_lo, 0);
    check("both_resp_kept", resp, 8'h05);
    check("both_frame_kept", frame, 48'h48_0000_01AA_87);

    // 6: reset mid-SEND, then a clean CMD0
    pat = {16'hFFFF, 8'h01, 40'hFF_FFFF_FFFF};
    pulse(1'b0, 1'b1, 6'd0, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      if (lowcnt >= 20) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_reached_bit20", ok, 1);
    #1 RST = 1'b1;
    #1;
    check("abort_cs", sd_cs, 1);
    check("abort_clk", sd_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_di", sd_di, 1);
    @(posedge CLK); #1;
    RST = 1'b0;
    snap();
    pulse(1'b0, 1'b1, 6'd0, 32'h0);
    finish_op("cmd0b");
    check("cmd0b_frame", frame, 48'h40_0000_0000_95);
    check("cmd0b_resp", resp, 8'h01);
    check("cmd0b_timeout", timeout, 0);
    check("cmd0b_rises", d_total, 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
